// File: rtl/multicycle_control32.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control32
// Brief    : FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle MIPS
//            datapath, with a bounded io_ready wait on memory-mapped IO.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control32 #(
  parameter int                   IO_HIGH_W   = 22,
  parameter logic [IO_HIGH_W-1:0] IO_BASE     = {IO_HIGH_W{1'b1}},
  parameter int                   IO_WAIT_MAX = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic [IO_HIGH_W-1:0] alu_result_high,
  input  logic                 zero,
  input  logic                 io_ready,
  output logic [2:0]           state,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 alu_src,
  output logic                 sftmd,
  output logic                 jal,
  output logic [1:0]           alu_op,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 io_read,
  output logic                 io_write,
  output logic                 mem_or_io_to_reg,
  output logic                 io_timeout,
  output logic                 illegal
);

  localparam int                 c_cnt_w    = $clog2(IO_WAIT_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_wait_max = c_cnt_w'(IO_WAIT_MAX);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [5:0]         c_funct_jr = 6'b001000;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE = 4'd0,
    CL_R    = 4'd1,
    CL_I    = 4'd2,
    CL_LW   = 4'd3,
    CL_SW   = 4'd4,
    CL_BEQ  = 4'd5,
    CL_BNE  = 4'd6,
    CL_J    = 4'd7,
    CL_JAL  = 4'd8,
    CL_ILL  = 4'd9
  } class_t;

  state_t             r_state;
  state_t             w_next_state;
  class_t             r_class;
  class_t             w_dec_class;
  logic [5:0]         r_funct;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_io_timeout;
  logic               w_set_timeout;
  logic               w_is_io;
  logic               w_is_r;
  logic               w_is_jr;

  assign w_is_io    = (alu_result_high == IO_BASE);
  assign w_is_r     = (r_class == CL_R);
  assign w_is_jr    = w_is_r && (r_funct == c_funct_jr);
  assign state      = r_state;
  assign io_timeout = r_io_timeout;

  always_comb begin
    w_dec_class = CL_ILL;
    if (opcode == 6'b000000) begin
      w_dec_class = CL_R;
    end else if (opcode[5:3] == 3'b001) begin
      w_dec_class = CL_I;
    end else begin
      case (opcode)
        6'b100011: w_dec_class = CL_LW;
        6'b101011: w_dec_class = CL_SW;
        6'b000100: w_dec_class = CL_BEQ;
        6'b000101: w_dec_class = CL_BNE;
        6'b000010: w_dec_class = CL_J;
        6'b000011: w_dec_class = CL_JAL;
        default:   w_dec_class = CL_ILL;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_RESET;
      r_class      <= CL_NONE;
      r_funct      <= 6'd0;
      r_cnt        <= '0;
      r_io_timeout <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Later states use only this copy; opcode is free to change after DECODE.
      if (r_state == S_DECODE) begin
        r_class <= w_dec_class;
        r_funct <= funct;
      end
      if (w_next_state == S_MEM) begin
        r_cnt <= (r_state == S_MEM) ? r_cnt + c_cnt_one : c_cnt_one;
      end
      if (w_set_timeout) begin
        r_io_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state     = S_FETCH;
    w_set_timeout    = 1'b0;
    pc_write         = 1'b0;
    ir_write         = 1'b0;
    pc_src           = 2'b00;
    reg_write        = 1'b0;
    reg_dst          = 1'b0;
    alu_src          = 1'b0;
    sftmd            = 1'b0;
    jal              = 1'b0;
    alu_op           = 2'b00;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    io_read          = 1'b0;
    io_write         = 1'b0;
    mem_or_io_to_reg = 1'b0;
    illegal          = 1'b0;

    case (r_state)
      S_RESET: w_next_state = S_FETCH;

      S_FETCH: begin
        ir_write     = 1'b1;
        pc_write     = 1'b1;
        w_next_state = S_DECODE;
      end

      S_DECODE: begin
        if (w_dec_class == CL_ILL) begin
          illegal      = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_src = (r_class == CL_I) || (r_class == CL_LW) || (r_class == CL_SW);
        alu_op  = {w_is_r || (r_class == CL_I), (r_class == CL_BEQ) || (r_class == CL_BNE)};
        sftmd   = w_is_r && (r_funct[5:3] == 3'b000);
        reg_dst = w_is_r;
        case (r_class)
          CL_BEQ: begin
            pc_write = zero;
            pc_src   = 2'b01;
          end
          CL_BNE: begin
            pc_write = !zero;
            pc_src   = 2'b01;
          end
          CL_J: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
          end
          CL_JAL: begin
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            jal       = 1'b1;
            reg_write = 1'b1;
          end
          CL_R: begin
            if (w_is_jr) begin
              pc_write = 1'b1;
              pc_src   = 2'b11;
            end else begin
              w_next_state = S_WB;
            end
          end
          CL_I:         w_next_state = S_WB;
          CL_LW, CL_SW: w_next_state = S_MEM;
          default:      w_next_state = S_FETCH;
        endcase
      end

      S_MEM: begin
        if (!w_is_io) begin
          mem_read     = (r_class == CL_LW);
          mem_write    = (r_class == CL_SW);
          w_next_state = (r_class == CL_LW) ? S_WB : S_FETCH;
        end else begin
          io_read  = (r_class == CL_LW);
          io_write = (r_class == CL_SW);
          if (io_ready) begin
            w_next_state = (r_class == CL_LW) ? S_WB : S_FETCH;
          end else if (r_cnt == c_wait_max) begin
            // Abandon the access: no writeback, flag stays until reset.
            w_set_timeout = 1'b1;
            w_next_state  = S_FETCH;
          end else begin
            w_next_state = S_MEM;
          end
        end
      end

      S_WB: begin
        reg_write        = 1'b1;
        reg_dst          = w_is_r;
        mem_or_io_to_reg = (r_class == CL_LW);
        w_next_state     = S_FETCH;
      end

      default: w_next_state = S_FETCH;
    endcase
  end

endmodule
`default_nettype wire
